// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction fields in, datapath controls out, for the multicycle controller
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       MemReady;

    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       Illegal;
    logic [3:0] State;

    modport master (
        input  op, funct3, funct7b5, Zero, MemReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal, State
    );

    modport slave (
        output op, funct3, funct7b5, Zero, MemReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore sequencer driving the shared-ALU multicycle RV32I datapath
module multicycle_controller (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_UPPER    = 4'd11,
        S_JALR     = 4'd12,
        S_JALRPC   = 4'd13,
        S_TRAP     = 4'd15
    } state_t;

    state_t state, state_next;

    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic       illegal;
    logic [3:0] funct_alu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // ALU word shared by EXECR and EXECI; only R-type (op[5]=1) may select sub
    always_comb begin
        funct_alu = ALU_ADD;
        case (bus.funct3)
            3'b000:  funct_alu = (bus.funct7b5 && bus.op[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  funct_alu = 4'b1010;
            3'b010:  funct_alu = 4'b0101;
            3'b011:  funct_alu = 4'b0110;
            3'b100:  funct_alu = 4'b0100;
            3'b101:  funct_alu = bus.funct7b5 ? 4'b1011 : 4'b1100;
            3'b110:  funct_alu = 4'b0011;
            default: funct_alu = 4'b0010;
        endcase
    end

    always_comb begin
        imm_src = 3'b000;
        case (bus.op)
            OP_STORE:         imm_src = 3'b001;
            OP_BRANCH:        imm_src = 3'b010;
            OP_JAL:           imm_src = 3'b011;
            OP_LUI, OP_AUIPC: imm_src = 3'b100;
            default:          imm_src = 3'b000;
        endcase
    end

    always_comb begin
        state_next  = S_FETCH;
        pc_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write   = bus.MemReady;
                pc_write   = bus.MemReady;
                state_next = bus.MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // ALUOut captures OldPC+imm for branch and jal targets
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI, OP_AUIPC:  state_next = S_UPPER;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                state_next = bus.MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_write  = 1'b1;
                state_next = bus.MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b00;
                alu_control = funct_alu;
                state_next  = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = funct_alu;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                result_src = 2'b00;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b00;
                alu_control = ALU_SUB;
                result_src  = 2'b00;
                case (bus.funct3)
                    3'b000:  pc_write = bus.Zero;
                    3'b001:  pc_write = ~bus.Zero;
                    default: pc_write = 1'b0;
                endcase
                state_next = S_FETCH;
            end
            S_JAL: begin
                // PC takes the DECODE target while the ALU forms the link value
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b00;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                result_src = 2'b11;
                reg_write  = 1'b1;
                state_next = S_JALRPC;
            end
            S_JALRPC: begin
                result_src = 2'b00;
                pc_write   = 1'b1;
                state_next = S_FETCH;
            end
            S_UPPER: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b01;
                alu_control = bus.op[5] ? 4'b1101 : 4'b1000;
                state_next  = S_ALUWB;
            end
            S_TRAP: begin
                illegal    = 1'b1;
                state_next = S_TRAP;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

    assign bus.PCWrite    = pc_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.MemWrite   = mem_write;
    assign bus.IRWrite    = ir_write;
    assign bus.RegWrite   = reg_write;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ImmSrc     = imm_src;
    assign bus.ALUControl = alu_control;
    assign bus.Illegal    = illegal;
    assign bus.State      = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - random instruction stream checked cycle by cycle against an expected trace
module tb_multicycle_controller;

    logic clk;
    logic reset;
    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       mr;
        logic       z;
        logic [3:0] st;
        logic       pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb;
        logic [3:0] alu;
    } cyc_t;

    cyc_t q[$];
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic       cur_f7;
    int total = 0;
    int bad   = 0;
    logic [6:0] ops [9];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(1, 0));
    endfunction

    function automatic logic [2:0] imm_ref(input logic [6:0] o);
        if (o == 7'b0100011) return 3'b001;
        if (o == 7'b1100011) return 3'b010;
        if (o == 7'b1101111) return 3'b011;
        if (o == 7'b0110111 || o == 7'b0010111) return 3'b100;
        return 3'b000;
    endfunction

    function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic f7, input logic op5);
        logic [3:0] t [8];
        t = '{4'b0000, 4'b1010, 4'b0101, 4'b0110, 4'b0100, 4'b1100, 4'b0011, 4'b0010};
        if (f3 == 3'd0 && f7 && op5) return 4'b0001;
        if (f3 == 3'd5 && f7) return 4'b1011;
        return t[f3];
    endfunction

    function automatic cyc_t blank(input logic [3:0] st, input logic mr);
        cyc_t c;
        c.op = cur_op; c.f3 = cur_f3; c.f7 = cur_f7;
        c.mr = mr; c.z = rb(); c.st = st;
        c.pcw = 0; c.adr = 0; c.mw = 0; c.irw = 0; c.rw = 0; c.ill = 0;
        c.rs = 0; c.sa = 0; c.sb = 0; c.alu = 0;
        return c;
    endfunction

    function automatic logic [31:0] pack(input cyc_t c);
        return {9'd0, c.pcw, c.adr, c.mw, c.irw, c.rw, c.rs, c.sa, c.sb,
                imm_ref(c.op), c.alu, c.ill, c.st};
    endfunction

    function automatic logic [31:0] observed();
        return {9'd0, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl,
                bus.Illegal, bus.State};
    endfunction

    task automatic push_wb();
        cyc_t c;
        c = blank(4'd7, rb()); c.rw = 1; q.push_back(c);
    endtask

    // Expected per-cycle trace for one instruction: fw fetch stalls, mw memory stalls
    task automatic gen_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic zb, input int fw, input int mw);
        cyc_t c;
        cur_op = o; cur_f3 = f3; cur_f7 = f7;
        for (int i = 0; i < fw; i++) begin
            c = blank(4'd0, 1'b0); c.sb = 2; c.rs = 2; q.push_back(c);
        end
        c = blank(4'd0, 1'b1); c.sb = 2; c.rs = 2; c.irw = 1; c.pcw = 1; q.push_back(c);
        c = blank(4'd1, rb()); c.sa = 1; c.sb = 1; q.push_back(c);
        case (o)
            7'b0000011, 7'b0100011: begin
                c = blank(4'd2, rb()); c.sa = 2; c.sb = 1; q.push_back(c);
                for (int i = 0; i <= mw; i++) begin
                    c = blank(o[5] ? 4'd5 : 4'd3, i == mw);
                    c.adr = 1; c.mw = o[5]; q.push_back(c);
                end
                if (!o[5]) begin
                    c = blank(4'd4, rb()); c.rs = 1; c.rw = 1; q.push_back(c);
                end
            end
            7'b0110011, 7'b0010011: begin
                c = blank(o[5] ? 4'd6 : 4'd8, rb());
                c.sa = 2; c.sb = o[5] ? 2'd0 : 2'd1; c.alu = alu_ref(f3, f7, o[5]);
                q.push_back(c); push_wb();
            end
            7'b1100011: begin
                c = blank(4'd10, rb()); c.z = zb; c.sa = 2; c.alu = 4'b0001;
                c.pcw = (f3 == 3'd0) ? zb : (f3 == 3'd1) ? !zb : 1'b0;
                q.push_back(c);
            end
            7'b1101111: begin
                c = blank(4'd9, rb()); c.sa = 1; c.sb = 2; c.pcw = 1; q.push_back(c); push_wb();
            end
            7'b1100111: begin
                c = blank(4'd12, rb()); c.sa = 2; c.sb = 1; c.rs = 3; c.rw = 1; q.push_back(c);
                c = blank(4'd13, rb()); c.pcw = 1; q.push_back(c);
            end
            7'b0110111, 7'b0010111: begin
                c = blank(4'd11, rb()); c.sa = 1; c.sb = 1;
                c.alu = o[5] ? 4'b1101 : 4'b1000; q.push_back(c); push_wb();
            end
            default: begin
                for (int i = 0; i < 10; i++) begin
                    c = blank(4'd15, rb()); c.ill = 1; q.push_back(c);
                end
            end
        endcase
    endtask

    task automatic run_queue();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk); #1;
            bus.op = c.op; bus.funct3 = c.f3; bus.funct7b5 = c.f7;
            bus.MemReady = c.mr; bus.Zero = c.z;
            @(negedge clk);
            check($sformatf("op%b_st%0d", c.op, c.st), observed(), pack(c));
        end
    endtask

    task automatic do_reset();
        bus.MemReady = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        cyc_t c;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        reset = 1'b1;
        bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
        bus.Zero = 1'b0; bus.MemReady = 1'b0;
        cur_op = 7'd0; cur_f3 = 3'd0; cur_f7 = 1'b0;
        repeat (2) @(negedge clk);
        c = blank(4'd0, 1'b0); c.sb = 2; c.rs = 2;
        check("reset_state", observed(), pack(c));
        bus.MemReady = 1'b1;
        @(negedge clk);
        c.irw = 1; c.pcw = 1;
        check("reset_memready", observed(), pack(c));
        bus.MemReady = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        gen_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0);
        gen_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0);
        gen_instr(7'b0010011, 3'd0, 1'b1, 1'b0, 1, 0);
        gen_instr(7'b0010011, 3'd5, 1'b1, 1'b0, 0, 0);
        gen_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 0, 2);
        gen_instr(7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0);
        gen_instr(7'b1100011, 3'd1, 1'b0, 1'b1, 0, 0);
        gen_instr(7'b1100011, 3'd4, 1'b0, 1'b1, 0, 0);
        gen_instr(7'b1100111, 3'd0, 1'b0, 1'b0, 0, 0);
        gen_instr(7'b0110111, 3'd0, 1'b0, 1'b0, 0, 0);
        gen_instr(7'b0010111, 3'd0, 1'b0, 1'b0, 2, 0);
        gen_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 0, 3);
        run_queue();

        for (int n = 0; n < 200; n++) begin
            gen_instr(ops[$urandom_range(8, 0)], 3'($urandom_range(7, 0)), rb(), rb(),
                      $urandom_range(2, 0), $urandom_range(2, 0));
            run_queue();
        end

        gen_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0);
        run_queue();
        do_reset();

        // Reset lands in the middle of a stalled store
        cur_op = 7'b0100011; cur_f3 = 3'd2; cur_f7 = 1'b0;
        c = blank(4'd0, 1'b1); c.sb = 2; c.rs = 2; c.irw = 1; c.pcw = 1; q.push_back(c);
        c = blank(4'd1, 1'b0); c.sa = 1; c.sb = 1; q.push_back(c);
        c = blank(4'd2, 1'b0); c.sa = 2; c.sb = 1; q.push_back(c);
        c = blank(4'd5, 1'b0); c.adr = 1; c.mw = 1; q.push_back(c);
        run_queue();
        #1 reset = 1'b1;
        #1;
        check("async_rst_state", 32'(bus.State), 32'd0);
        check("async_rst_memwrite", 32'(bus.MemWrite), 32'd0);
        bus.MemReady = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("post_rst_regwrite", 32'(bus.RegWrite), 32'd0);

        gen_instr(7'b0110011, 3'd7, 1'b0, 1'b0, 1, 0);
        run_queue();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style sequencer for the multicycle RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback states. It drives all datapath enables and mux selects, and generates the 4-bit ALU control word for the shared ALU. It sits between the instruction register and the shared ALU / register file / unified memory datapath, and replaces per-instruction combinational control.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; forces state to FETCH.
- op  in  7  instr[6:0] from instruction register.
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- Zero  in  1  ALU zero flag (current cycle).
- MemReady  in  1  memory handshake; 1 = access completes this cycle.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  0 = PC, 1 = ALUOut to memory address.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction/OldPC register enable.
- RegWrite  out  1  register file write enable.
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 PC.
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 (A reg).
- ALUSrcB  out  2  00 rs2 (WriteData reg), 01 ImmExt, 10 constant 4.
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U; decoded from op; 000 otherwise.
- ALUControl  out  4  ALU operation.
- Illegal  out  1  sticky trap indicator.
- State  out  4  current state, for debug.

## Operation
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BRANCH 10, UPPER 11, JALR 12, JALRPC 13, TRAP 15. Codes 14 and unused states go to FETCH.
- FETCH: AdrSrc=0, SrcA=00, SrcB=10, ALUOp add, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE: SrcA=01, SrcB=01, add (ALUOut <= branch/jal target). Next state by op:
  - 0000011 / 0100011 → MEMADR.
  - 0110011 → EXECR.
  - 0010011 → EXECI.
  - 1100011 → BRANCH.
  - 1101111 → JAL.
  - 1100111 → JALR.
  - 0110111 / 0010111 → UPPER.
  - Any other op → TRAP.
- MEMADR: SrcA=10, SrcB=01, add. Goes to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: AdrSrc=1. Holds until MemReady, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until MemReady, then → FETCH.
- EXECR: SrcA=10, SrcB=00, funct decode → ALUWB.
- EXECI: SrcA=10, SrcB=01, funct decode → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BRANCH: SrcA=10, SrcB=00, sub, ResultSrc=00. PCWrite is taken (funct3 000: Zero; 001: !Zero; other funct3: 0) → FETCH.
- JAL: SrcA=01, SrcB=10, add, ResultSrc=00, PCWrite=1 → ALUWB.
- JALR: SrcA=10, SrcB=01, add, ResultSrc=11, RegWrite=1. This writes rd <= PC (= OldPC+4) → JALRPC.
- JALRPC: ResultSrc=00, PCWrite=1 → FETCH.
- UPPER: SrcA=01, SrcB=01. ALUControl is 1101 (LUI) if op[5]=1, else 1000 (AUIPC) → ALUWB.
- TRAP: all enables 0, Illegal=1, State=15. Exits only on reset.
- Every output not listed for a state is 0.
- ALUControl:
  - add states: 0000.
  - BRANCH: 0001.
  - funct decode:
    - funct3 000: 0001 if funct7b5 & op[5], else 0000.
    - 001: 1010.
    - 010: 0101.
    - 011: 0110.
    - 100: 0100.
    - 101: 1011 if funct7b5, else 1100.
    - 110: 0011.
    - 111: 0010.

## Timing
- State register updates on rising clk. All outputs are combinational from State, op, funct3, funct7b5, Zero and MemReady.
- Reset (async): State=FETCH immediately.
  - Outputs then show FETCH values: IRWrite/PCWrite follow MemReady but have no effect until reset deasserts.
  - Reset mid-instruction abandons the instruction; no partial writeback after deassertion.
- Cycles with MemReady=1 throughout:
  - 3 cycles: branch.
  - 4 cycles: R/I-ALU, sw, jal, jalr, lui, auipc.
  - 5 cycles: lw.
  - Each MemReady=0 cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- MemWrite stays high for every wait cycle of MEMWRITE and drops in the cycle after MemReady=1.
- Exactly one PCWrite pulse occurs per FETCH completion. A taken branch, JAL or JALRPC adds one more.
- Zero is sampled only in BRANCH.
- op/funct fields are assumed stable from the FETCH-completion edge onward.

## Test plan
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), MemReady=1 → states 0,1,6,7,0; ALUControl 0000 in EXECR; RegWrite only in ALUWB.
- sub (f7b5=1, op[5]=1) → ALUControl 0001; addi with f7b5=1 (op 0010011) → 0000; srai (f3 101, f7b5 1) → 1011.
- lw with MemReady low 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0; RegWrite with ResultSrc=01 once.
- beq Zero=1 → PCWrite high in BRANCH; bne Zero=1 → PCWrite low; f3=100 → never taken; 3 cycles total.
- jalr → JALR has RegWrite=1, ResultSrc=11; JALRPC has PCWrite=1, ResultSrc=00; lui → ALUControl 1101, auipc → 1000.
- op 1111111 → TRAP, Illegal=1, all enables 0 for 10 cycles; assert reset mid-MEMWRITE → State=0 asynchronously, MemWrite drops same instant.
